uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   UART transmitter for the soc2 peripheral block: the transmit side matching the UART receiver already in the block.
//   Bytes from the peripheral bus glue enter through a valid/ready handshake into a small FIFO.
//   Each byte is serialised onto uart_tx as 8N1-style frames: start bit, 8 data bits LSB first, STOP_BITS stop bits.
//   Baud timing comes from a clock divider; frames are sent back-to-back while the FIFO holds data.
// PARAMETERS
//   CLK_DIV     434  clk cycles per bit (25 MHz / 57600); legal range >= 2
//   FIFO_DEPTH  4    FIFO entries; power of two, >= 2
//   STOP_BITS   1    number of stop bits, 1 or 2
// PORTS
//   clk         in   1   system clock; everything is sampled on the rising edge
//   reset       in   1   synchronous reset, active-high
//   tx_data     in   8   byte to transmit
//   tx_valid    in   1   tx_data is valid
//   tx_ready    out  1   FIFO can accept a byte; equals ~fifo_full
//   uart_tx     out  1   serial line, registered, idles high
//   tx_busy     out  1   a frame is in progress or the FIFO is non-empty
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO, excluding the shifter
// BEHAVIOUR
//   Reset values: uart_tx=1, tx_busy=0, fifo_count=0, tx_ready=1 (FIFO empty).
//     The FSM is forced to IDLE, the FIFO pointers are cleared, and the baud counter and bit counter are cleared.
//   Handshake: a byte is accepted on an edge where tx_valid && tx_ready.
//     tx_data must be held until it is accepted. tx_ready does not depend on tx_valid.
//   FIFO: write pointer and read pointer are each $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
//     full  = (wptr ^ rptr) == {1'b1, zeros}
//     empty = (wptr == rptr)
//     Push and pop on the same edge are allowed at any fill level where the push is legal; fifo_count is then unchanged.
//     A push while full is impossible, because tx_ready=0.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE:  if the FIFO is non-empty, pop into the 8-bit shifter and go to START.
//     START: uart_tx=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
//     DATA:  uart_tx=shifter[0]. Each bit lasts CLK_DIV cycles; shift right; bit_idx increments.
//            After bit_idx reaches 7 and its period ends, go to STOP.
//     STOP:  uart_tx=1 for STOP_BITS*CLK_DIV cycles. At the end of the period:
//            if the FIFO is non-empty, pop and go directly to START (no idle gap);
//            otherwise go to IDLE.
//   Baud counter: counts 0..CLK_DIV-1, restarts at 0 on every state entry and wraps at CLK_DIV-1.
//     The bit advance happens on the wrap edge.
//   Latency: a byte accepted at edge N into an empty FIFO while the FSM is IDLE is popped at edge N+1.
//     uart_tx falls at edge N+2. The frame lasts exactly (9+STOP_BITS)*CLK_DIV cycles from that fall.
//   Capacity: FIFO_DEPTH bytes in the FIFO plus 1 byte in the shifter.
//   tx_busy = (state != IDLE) | ~empty. tx_busy is registered from next-state, so it rises on the same edge the FIFO becomes non-empty.
//   Reset mid-frame: the reset edge forces uart_tx=1 and flushes the FIFO. The partial frame is abandoned, with no stop bit appended.
//   tx_data is ignored when tx_valid=0. X on tx_data while tx_valid=0 must not propagate.
// TESTING  (CLK_DIV=4, FIFO_DEPTH=4, STOP_BITS=1 unless noted)
//   1. Reset held for 10 cycles, then released, no traffic -> uart_tx=1, tx_ready=1, tx_busy=0, fifo_count=0 for 100 cycles.
//   2. Send 0xA5 at edge N -> uart_tx low at N+2 for 4 cycles;
//      then bits 1,0,1,0,0,1,0,1 at 4 cycles each; then high for 4 cycles;
//      tx_busy drops at N+42.
//   3. Hold tx_valid=1 with bytes 0x01..0x06 -> 5 bytes accepted (1 popped to shifter + 4 in FIFO);
//      tx_ready=0 and fifo_count=4 after the 5th acceptance;
//      the 6th byte is accepted one cycle after the first frame's stop bit ends.
//   4. Back-to-back 0x00 then 0xFF -> the second start bit begins on the cycle after the first stop bit ends;
//      line sampled every 4 cycles reads 0,0x00 bits,1,0,0xFF bits,1.
//   5. Assert reset during DATA bit 3 with 2 bytes queued -> next edge uart_tx=1, fifo_count=0, tx_busy=0;
//      no further frame after reset is released.
//   6. STOP_BITS=2, send 0x3C -> stop level lasts 8 cycles; total frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1-style UART serialiser (start, 8 data LSB first, STOP_BITS stop).
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [PW-1:0] FULL_XOR = PW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0]    STOP_MAX = 3'(STOP_BITS - 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shifter, shifter_nxt;
    logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic [7:0]    mem [FIFO_DEPTH];

    logic          push, pop, empty, empty_nxt, full_nxt, baud_wrap, line_c, busy_c;
    logic [PW-1:0] count_nxt;

    // tx_ready is a registered copy of ~full, so it never depends on tx_valid
    assign push      = tx_valid & tx_ready;
    assign empty     = (wptr == rptr);
    assign baud_wrap = (baud_cnt == BAUD_MAX);

    // Next-state, pop decision and line level for the current state
    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_wrap ? '0 : baud_cnt + CW'(1);
        bit_idx_nxt = bit_idx;
        shifter_nxt = shifter;
        pop         = 1'b0;
        line_c      = 1'b1;
        case (state)
            S_IDLE: begin
                baud_nxt    = '0;
                bit_idx_nxt = '0;
                if (!empty) begin
                    pop         = 1'b1;
                    shifter_nxt = mem[rptr[AW-1:0]];
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                line_c = 1'b0;
                if (baud_wrap) begin
                    state_nxt   = S_DATA;
                    bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                line_c = shifter[0];
                if (baud_wrap) begin
                    shifter_nxt = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt   = S_STOP;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                // Stop period: bit_idx counts stop bits so the wrap still marks every bit boundary
                line_c = 1'b1;
                if (baud_wrap) begin
                    if (bit_idx == STOP_MAX) begin
                        bit_idx_nxt = '0;
                        if (!empty) begin
                            pop         = 1'b1;
                            shifter_nxt = mem[rptr[AW-1:0]];
                            state_nxt   = S_START;
                        end else begin
                            state_nxt   = S_IDLE;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
        endcase
    end

    // FIFO pointer and status look-ahead so status outputs can be registered
    always_comb begin
        wptr_nxt  = wptr + PW'(push);
        rptr_nxt  = rptr + PW'(pop);
        count_nxt = wptr_nxt - rptr_nxt;
        empty_nxt = (wptr_nxt == rptr_nxt);
        full_nxt  = ((wptr_nxt ^ rptr_nxt) == FULL_XOR);
        // Busy holds one extra cycle after the FSM leaves STOP to cover the registered line's last stop bit
        busy_c    = (state_nxt != S_IDLE) | (state != S_IDLE) | ~empty_nxt;
    end

    // FIFO storage; data only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= tx_data;
        end
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shifter    <= '0;
            wptr       <= '0;
            rptr       <= '0;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
            fifo_count <= '0;
            tx_ready   <= 1'b1;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= bit_idx_nxt;
            shifter    <= shifter_nxt;
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            uart_tx    <= line_c;
            tx_busy    <= busy_c;
            fifo_count <= count_nxt;
            tx_ready   <= ~full_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; accepted bytes are queued, a line monitor decodes frames and compares.
module tb_uart_tx_fifo;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, tx_busy;
    logic [2:0] fifo_count;

    logic [7:0] data2 = 8'h00;
    logic       valid2 = 1'b0;
    logic       ready2, uart2, busy2;
    logic [2:0] count2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_count = 0;
    int acc2_count = 0;
    int acc2_cyc = 0;
    bit inv_on = 1'b0;

    logic [7:0] exp_q [$];
    int         acc_log [$];
    int         falls [$];

    uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .tx_data(data2), .tx_valid(valid2),
        .tx_ready(ready2), .uart_tx(uart2), .tx_busy(busy2), .fifo_count(count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance tracker: every handshake pushes the byte the line must later carry
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                acc_log.push_back(cyc);
                acc_count++;
            end
            if (valid2 && ready2) begin
                acc2_count++;
                acc2_cyc = cyc;
            end
        end
    end

    // Handshake invariant: ready is exactly "FIFO not full"
    always @(negedge clk) begin
        if (inv_on && !reset) begin
            check("ready_vs_count", int'(tx_ready), int'(fifo_count != 3'd4));
        end
    end

    // Line monitor: decode one frame per falling edge, checking every sample of every bit
    initial begin : line_mon
        int         fall;
        bit         ok, aborted;
        logic [7:0] b;
        logic       first;
        forever begin
            @(negedge clk);
            if (reset || uart_tx) continue;
            fall = cyc; ok = 1'b1; aborted = 1'b0; b = '0; first = 1'b0;
            for (int j = 0; j < 10; j++) begin
                for (int s = 0; s < D; s++) begin
                    if (!(j == 0 && s == 0)) @(negedge clk);
                    if (reset) aborted = 1'b1;
                    if (s == 0) first = uart_tx;
                    else if (uart_tx !== first) ok = 1'b0;
                    if (j == 0 && uart_tx !== 1'b0) ok = 1'b0;
                    if (j >= 1 && j <= 8 && s == 0) b[j-1] = uart_tx;
                    if (j == 9 && uart_tx !== 1'b1) ok = 1'b0;
                end
            end
            if (aborted) continue;
            falls.push_back(fall);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", int'(b), -1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("frame_framing_ok", int'(ok), 1);
                check("frame_byte", int'(b), int'(e));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n0;
        n0 = acc_count;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (acc_count != n0) break;
        end
        if (acc_count == n0) check("send_timeout", 0, 1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", int'(exp_q.size() != 0 || tx_busy), 0);
    endtask

    function automatic logic line_at(input int i, input logic [7:0] b);
        int bitn;
        if (i < 0) return 1'b1;
        bitn = i / D;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[bitn-1];
        return 1'b1;
    endfunction

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, t, bad_tx, bad_rdy, bad_busy, bad_cnt, base, nf, m, mism, bdrop;

        // T1: reset 10 cycles, then 100 idle cycles
        repeat (10) @(negedge clk);
        reset = 1'b0;
        bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || uart2 !== 1'b1) bad_tx++;
            if (tx_ready !== 1'b1 || ready2 !== 1'b1) bad_rdy++;
            if (tx_busy !== 1'b0 || busy2 !== 1'b0) bad_busy++;
            if (fifo_count !== 3'd0 || count2 !== 3'd0) bad_cnt++;
        end
        check("idle_uart_tx_high", bad_tx, 0);
        check("idle_tx_ready", bad_rdy, 0);
        check("idle_tx_busy_low", bad_busy, 0);
        check("idle_fifo_count", bad_cnt, 0);
        inv_on = 1'b1;

        // T2: single byte latency and busy window
        send_byte(8'hA5);
        n = acc_log[$];
        check("t2_busy_rises_on_accept", int'(tx_busy), 1);
        t = 0;
        while (uart_tx && t < 20) begin @(negedge clk); t++; end
        check("t2_start_fall_cycle", cyc - n, 2);
        t = 0;
        while (tx_busy && t < 200) begin @(negedge clk); t++; end
        check("t2_busy_drop_cycle", cyc - n, 42);
        drain();

        // T3: hold valid with 0x01..0x06; capacity is FIFO plus shifter
        base = acc_log.size();
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i));
            if (i == 5) begin
                check("t3_count_full", int'(fifo_count), 4);
                check("t3_ready_low_full", int'(tx_ready), 0);
            end
        end
        check("t3_fifth_accept", acc_log[base+4] - acc_log[base], 4);
        check("t3_sixth_accept", acc_log[base+5] - acc_log[base], 42);
        drain();

        // T4: back-to-back 0x00, 0xFF with no idle gap
        nf = falls.size();
        send_byte(8'h00);
        send_byte(8'hFF);
        drain();
        if (falls.size() < nf + 2) check("t4_frames_seen", falls.size(), nf + 2);
        else check("t4_frame_gap", falls[nf+1] - falls[nf], 10 * D);

        // Random traffic: random bytes, random gaps, garbage data while valid is low
        repeat (40) begin
            t = int'($urandom_range(0, 30));
            if (t > 20) t = 0;
            repeat (t) begin
                tx_data = 8'($urandom);
                @(negedge clk);
            end
            send_byte(8'($urandom));
        end
        drain();

        // T6: two stop bits on the second instance
        @(negedge clk);
        data2  = 8'h3C;
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        data2  = 8'($urandom);
        m = acc2_cyc;
        check("t6_accepted", acc2_count, 1);
        mism = 0; bdrop = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (uart2 !== line_at(cyc - m - 2, 8'h3C)) mism++;
            if (bdrop < 0 && !busy2) bdrop = cyc;
        end
        check("t6_waveform", mism, 0);
        check("t6_frame_len_busy", bdrop - m, 46);

        // T5: reset during data bit 3 with 2 bytes queued
        @(negedge clk);
        send_byte(8'h11);
        n = acc_log[$];
        send_byte(8'h22);
        send_byte(8'h33);
        t = 0;
        while (cyc < n + 19 && t < 100) begin @(negedge clk); t++; end
        check("t5_pre_count", int'(fifo_count), 2);
        check("t5_pre_line_bit3", int'(uart_tx), 0);
        inv_on = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t5_reset_line_high", int'(uart_tx), 1);
        check("t5_reset_count", int'(fifo_count), 0);
        check("t5_reset_busy", int'(tx_busy), 0);
        check("t5_reset_ready", int'(tx_ready), 1);
        reset = 1'b0;
        bad_tx = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad_tx++;
        end
        check("t5_quiet_after_reset", bad_tx, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
